exe_stage: RTL and testbench
============================

Name: exe_stage

Overview:
- Consumer end of the ID→EXE pipeline interface. Takes the registered decode bundle (control, operands, shift operand, branch offset, dest) and executes it.
- Computes the shifter operand (Val2), runs the ALU, and maintains the NZCV status register.
- Resolves branches into a target address plus a flush request back to the IF/ID registers.
- Registers results into the EXE/MEM boundary, which holds during memory stalls.

Parameters:
DATA_W, 32, datapath width; only 32 is supported, and rotate/shift rules assume 32.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
freeze  in  1  memory-side stall; hold EXE/MEM register and status
WB_EN_in  in  1  writeback enable from ID/EXE
Mem_R_EN_in  in  1  load enable
Mem_W_EN_in  in  1  store enable
EXE_CMD_in  in  4  ALU command
B_in  in  1  branch
S_in  in  1  update status
imm_in  in  1  immediate operand select
pc_in  in  32  PC+4 of the instruction
Val_Rn_in  in  32  first operand
Val_Rm_in  in  32  second register / store data
shift_operand_in  in  12  ARM shifter_operand field
signed_imm_24_in  in  24  branch offset (words)
dest_in  in  4  destination register
br_taken  out  1  flush request = B_in (combinational)
br_addr  out  32  branch target (combinational)
status  out  4  NZCV register {N,Z,C,V}
WB_EN  out  1  registered
Mem_R_EN  out  1  registered
Mem_W_EN  out  1  registered
alu_result  out  32  registered ALU result or memory address
st_val  out  32  registered Val_Rm_in
dest  out  4  registered destination

Behaviour:
- EXE_CMD encoding:
  - 0001 MOV, 1001 MVN
  - 0010 ADD (also LDR/STR address), 0011 ADC
  - 0100 SUB/CMP, 0101 SBC
  - 0110 AND/TST, 0111 ORR, 1000 EOR
  - any other code: result 0, flags unchanged.
- Val2 selection:
  - imm_in=1: {24'b0, so[7:0]} rotated right by 2*so[11:8].
  - Else if Mem_R_EN_in|Mem_W_EN_in: zero-extended so[11:0].
  - Else: Val_Rm_in shifted by so[11:7], with type so[6:5] (00 LSL, 01 LSR, 10 ASR, 11 ROR).
  - Shift amount 0 means no shift for every type.
- ALU arithmetic:
  - ADD: Rn+Val2. ADC: Rn+Val2+C.
  - SUB: Rn−Val2. SBC: Rn−Val2−!C.
  - C for add is the carry-out; C for sub is NOT borrow (ARM convention).
  - V (add): sign(Rn)==sign(Val2) && sign(res)!=sign(Rn).
  - V (sub): sign(Rn)!=sign(Val2) && sign(res)!=sign(Rn).
  - Logical ops and MOV/MVN: C and V keep their previous values.
  - N=res[31]; Z=(res==0).
- Status register:
  - Rising edge with rst → 0000.
  - Else if !freeze && S_in && !B_in → new NZCV.
  - Otherwise holds.
  - ADC/SBC carry-in is the pre-edge C.
- Branch path:
  - br_addr = pc_in + ({{6{imm24[23]}}, imm24, 2'b00}).
  - br_taken = B_in; this is zero latency and independent of freeze.
- EXE/MEM register:
  - rst: all registered outputs cleared to 0 (WB_EN, Mem_R_EN, Mem_W_EN, alu_result, st_val, dest).
  - freeze=1: all hold.
  - Otherwise they load the inputs/result.
  - A branch instruction loads with WB_EN=Mem_R_EN=Mem_W_EN=0.
- Simultaneous events:
  - rst overrides freeze and S.
  - freeze overrides S: the status update is deferred, and the same instruction re-presents on the next cycle.
- Latency: 1 cycle for registered outputs; 0 for br_taken/br_addr.

Decomposition:
- Shared package `arm_defs`: EXE_CMD localparams, shift-type codes, NZCV bit indices.
- Sub-module `val2_gen`: combinational shifter-operand generator, reusable by forwarding/test code.
- ALU, status register and EXE/MEM register stay inline.

Test Plan:
1. rst=1 for 2 cycles with random inputs → all registered outputs 0, status=0000; holding freeze=1 during reset changes nothing.
2. ADD S=1, Rn=0x7FFFFFFF, imm=1, so=0x001 → alu_result=0x80000000, status=1001.
3. SUB S=1, Rn=5, Val2=5 → result 0, status=0110; then SBC Rn=5, Val2=2 (C=1) → result 3.
4. MOV with so = shift_imm 4, ROR, Rm=0x0000000F → result 0xF0000000; status unchanged because S=0.
5. imm=1, so=0x4FF → Val2=0xFF000000; LDR with so=0x123, Rn=0x100 → address 0x223.
6. B_in=1, pc=0x100, imm24=0xFFFFFE → br_taken=1, br_addr=0xF8 same cycle; registered enables 0. Separately, freeze=1 for 3 cycles → outputs and status frozen.

Source files
------------

// File: rtl/exe_stage_pkg.sv
// Shared ARM execute-stage definitions: ALU command codes, shifter types and NZCV bit positions.
package arm_defs;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/exe_stage_if.sv
// ID->EXE pipeline bundle; the decode register drives it, the execute stage consumes it.
interface exe_stage_if;
  logic        WB_EN_in;
  logic        Mem_R_EN_in;
  logic        Mem_W_EN_in;
  logic [3:0]  EXE_CMD_in;
  logic        B_in;
  logic        S_in;
  logic        imm_in;
  logic [31:0] pc_in;
  logic [31:0] Val_Rn_in;
  logic [31:0] Val_Rm_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [3:0]  dest_in;

  modport master (
    output WB_EN_in, Mem_R_EN_in, Mem_W_EN_in, EXE_CMD_in, B_in, S_in, imm_in, pc_in,
           Val_Rn_in, Val_Rm_in, shift_operand_in, signed_imm_24_in, dest_in
  );

  modport slave (
    input WB_EN_in, Mem_R_EN_in, Mem_W_EN_in, EXE_CMD_in, B_in, S_in, imm_in, pc_in,
          Val_Rn_in, Val_Rm_in, shift_operand_in, signed_imm_24_in, dest_in
  );
endinterface

// File: rtl/exe_stage_val2_gen.sv
// Combinational ARM shifter-operand (Val2) generator: rotated immediate, memory offset or
// shifted register.
module val2_gen
  import arm_defs::*;
(
  input  logic [31:0] val_rm,
  input  logic [11:0] shift_operand,
  input  logic        imm,
  input  logic        mem_en,
  output logic [31:0] val2
);

  logic [31:0] imm8;
  logic [63:0] rot_imm;
  logic [63:0] rot_rm;
  logic [4:0]  amt;

  assign imm8    = {24'b0, shift_operand[7:0]};
  assign amt     = shift_operand[11:7];
  assign rot_imm = {imm8, imm8} >> {shift_operand[11:8], 1'b0};
  assign rot_rm  = {val_rm, val_rm} >> amt;

  // A zero shift amount leaves val_rm untouched for all four types, so no special case.
  always_comb begin
    val2 = val_rm;
    if (imm) begin
      val2 = rot_imm[31:0];
    end else if (mem_en) begin
      val2 = {20'b0, shift_operand};
    end else begin
      case (shift_operand[6:5])
        SH_LSL:  val2 = val_rm << amt;
        SH_LSR:  val2 = val_rm >> amt;
        SH_ASR:  val2 = 32'($signed(val_rm) >>> amt);
        SH_ROR:  val2 = rot_rm[31:0];
        default: val2 = val_rm;
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: Val2 generation, ALU, NZCV status, branch resolution and EXE/MEM register.
module exe_stage
  import arm_defs::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  exe_stage_if.slave        id,
  output logic              br_taken,
  output logic [DATA_W-1:0] br_addr,
  output logic [3:0]        status,
  output logic              WB_EN,
  output logic              Mem_R_EN,
  output logic              Mem_W_EN,
  output logic [DATA_W-1:0] alu_result,
  output logic [DATA_W-1:0] st_val,
  output logic [3:0]        dest
);

  logic [31:0] val2;
  logic [31:0] rn;
  logic [32:0] add_sum;
  logic [32:0] sub_sum;
  logic        add_cin;
  logic        sub_cin;
  logic [31:0] alu_res;
  logic        c_new;
  logic        v_new;
  logic        known;
  logic [3:0]  status_d;

  val2_gen u_val2_gen (
    .val_rm        (id.Val_Rm_in),
    .shift_operand (id.shift_operand_in),
    .imm           (id.imm_in),
    .mem_en        (id.Mem_R_EN_in | id.Mem_W_EN_in),
    .val2          (val2)
  );

  assign rn = id.Val_Rn_in;

  // Subtraction is Rn + ~Val2 + cin, so the carry-out is already ARM's NOT-borrow.
  assign add_cin = (id.EXE_CMD_in == EXE_ADC) & status[FLAG_C];
  assign sub_cin = (id.EXE_CMD_in == EXE_SUB) | status[FLAG_C];
  assign add_sum = {1'b0, rn} + {1'b0, val2} + {32'b0, add_cin};
  assign sub_sum = {1'b0, rn} + {1'b0, ~val2} + {32'b0, sub_cin};

  always_comb begin
    alu_res = '0;
    c_new   = status[FLAG_C];
    v_new   = status[FLAG_V];
    known   = 1'b1;
    case (id.EXE_CMD_in)
      EXE_MOV: alu_res = val2;
      EXE_MVN: alu_res = ~val2;
      EXE_ADD, EXE_ADC: begin
        alu_res = add_sum[31:0];
        c_new   = add_sum[32];
        v_new   = (rn[31] == val2[31]) && (add_sum[31] != rn[31]);
      end
      EXE_SUB, EXE_SBC: begin
        alu_res = sub_sum[31:0];
        c_new   = sub_sum[32];
        v_new   = (rn[31] != val2[31]) && (sub_sum[31] != rn[31]);
      end
      EXE_AND: alu_res = rn & val2;
      EXE_ORR: alu_res = rn | val2;
      EXE_EOR: alu_res = rn ^ val2;
      default: known = 1'b0;
    endcase

    status_d = status;
    if (known) begin
      status_d[FLAG_N] = alu_res[31];
      status_d[FLAG_Z] = (alu_res == 32'b0);
      status_d[FLAG_C] = c_new;
      status_d[FLAG_V] = v_new;
    end
  end

  assign br_taken = id.B_in;
  assign br_addr  = id.pc_in + {{6{id.signed_imm_24_in[23]}}, id.signed_imm_24_in, 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      status <= 4'b0;
    end else if (!freeze && id.S_in && !id.B_in) begin
      status <= status_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      WB_EN      <= 1'b0;
      Mem_R_EN   <= 1'b0;
      Mem_W_EN   <= 1'b0;
      alu_result <= '0;
      st_val     <= '0;
      dest       <= 4'b0;
    end else if (!freeze) begin
      WB_EN      <= id.WB_EN_in & ~id.B_in;
      Mem_R_EN   <= id.Mem_R_EN_in & ~id.B_in;
      Mem_W_EN   <= id.Mem_W_EN_in & ~id.B_in;
      alu_result <= alu_res;
      st_val     <= id.Val_Rm_in;
      dest       <= id.dest_in;
    end
  end

endmodule

// File: tb/tb_exe_stage.sv
// Self-checking bench for exe_stage: directed vector table, branch/freeze sequences and random
// stimulus against an arithmetic reference model.
module tb_exe_stage;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        br_taken;
  logic [31:0] br_addr;
  logic [3:0]  status;
  logic        WB_EN, Mem_R_EN, Mem_W_EN;
  logic [31:0] alu_result, st_val;
  logic [3:0]  dest;

  exe_stage_if bus ();

  exe_stage dut (
    .clk        (clk),
    .rst        (rst),
    .freeze     (freeze),
    .id         (bus),
    .br_taken   (br_taken),
    .br_addr    (br_addr),
    .status     (status),
    .WB_EN      (WB_EN),
    .Mem_R_EN   (Mem_R_EN),
    .Mem_W_EN   (Mem_W_EN),
    .alu_result (alu_result),
    .st_val     (st_val),
    .dest       (dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference-model expectations for the registered outputs.
  logic        e_wb, e_mr, e_mw;
  logic [31:0] e_res, e_st;
  logic [3:0]  e_dest;
  logic [3:0]  m_status;

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, mr, mw;
    logic [31:0] rn, rm;
    logic [11:0] so;
    logic [31:0] exp_res;
    logic [3:0]  exp_st;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_val2(input logic imm, input logic mem,
                                           input logic [11:0] so, input logic [31:0] rm);
    logic [31:0] x;
    int r;
    if (imm) begin
      x = {24'b0, so[7:0]};
      r = so[11:8] * 2;
      return (r == 0) ? x : ((x >> r) | (x << (32 - r)));
    end
    if (mem) return {20'b0, so};
    r = so[11:7];
    if (r == 0) return rm;
    case (so[6:5])
      2'd0:    return rm << r;
      2'd1:    return rm >> r;
      2'd2:    return rm[31] ? ~((~rm) >> r) : (rm >> r);
      default: return (rm >> r) | (rm << (32 - r));
    endcase
  endfunction

  function automatic void ref_exec(output logic [31:0] res, output logic [3:0] nz,
                                   output logic known);
    longint a, b, sa, sb, t, ts, cin;
    logic [31:0] v2;
    logic c, v;
    v2 = ref_val2(bus.imm_in, bus.Mem_R_EN_in | bus.Mem_W_EN_in, bus.shift_operand_in,
                  bus.Val_Rm_in);
    a  = {32'b0, bus.Val_Rn_in};
    b  = {32'b0, v2};
    sa = longint'($signed(bus.Val_Rn_in));
    sb = longint'($signed(v2));
    c  = m_status[1];
    v  = m_status[0];
    known = 1'b1;
    res = 32'b0;
    case (bus.EXE_CMD_in)
      4'd1: res = v2;
      4'd9: res = ~v2;
      4'd2, 4'd3: begin
        cin = (bus.EXE_CMD_in == 4'd3 && m_status[1]) ? 1 : 0;
        t  = a + b + cin;
        ts = sa + sb + cin;
        res = t[31:0];
        c = (t >= 64'sd4294967296);
        v = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
      end
      4'd4, 4'd5: begin
        cin = (bus.EXE_CMD_in == 4'd5 && !m_status[1]) ? 1 : 0;
        t  = a - b - cin;
        ts = sa - sb - cin;
        res = t[31:0];
        c = (t >= 0);
        v = (ts > 64'sd2147483647) || (ts < -64'sd2147483648);
      end
      4'd6: res = bus.Val_Rn_in & v2;
      4'd7: res = bus.Val_Rn_in | v2;
      4'd8: res = bus.Val_Rn_in ^ v2;
      default: known = 1'b0;
    endcase
    nz = {res[31], res == 32'b0, c, v};
  endfunction

  // One clock: check branch outputs before the edge, then all registered outputs after it.
  task automatic step(input string tag);
    logic [31:0] res, off;
    logic [3:0]  nz;
    logic        known;
    #1;
    off = {{8{bus.signed_imm_24_in[23]}}, bus.signed_imm_24_in};
    chk($sformatf("%s/br_taken", tag), {31'b0, br_taken}, {31'b0, bus.B_in});
    chk($sformatf("%s/br_addr", tag), br_addr, bus.pc_in + off * 4);
    ref_exec(res, nz, known);
    @(posedge clk);
    #1;
    if (rst) begin
      {e_wb, e_mr, e_mw} = 3'b0;
      e_res = 0; e_st = 0; e_dest = 0; m_status = 0;
    end else if (!freeze) begin
      e_wb   = bus.WB_EN_in && !bus.B_in;
      e_mr   = bus.Mem_R_EN_in && !bus.B_in;
      e_mw   = bus.Mem_W_EN_in && !bus.B_in;
      e_res  = res;
      e_st   = bus.Val_Rm_in;
      e_dest = bus.dest_in;
      if (bus.S_in && !bus.B_in && known) m_status = nz;
    end
    chk($sformatf("%s/WB_EN", tag), {31'b0, WB_EN}, {31'b0, e_wb});
    chk($sformatf("%s/Mem_R_EN", tag), {31'b0, Mem_R_EN}, {31'b0, e_mr});
    chk($sformatf("%s/Mem_W_EN", tag), {31'b0, Mem_W_EN}, {31'b0, e_mw});
    chk($sformatf("%s/alu_result", tag), alu_result, e_res);
    chk($sformatf("%s/st_val", tag), st_val, e_st);
    chk($sformatf("%s/dest", tag), {28'b0, dest}, {28'b0, e_dest});
    chk($sformatf("%s/status", tag), {28'b0, status}, {28'b0, m_status});
  endtask

  task automatic rand_inputs();
    bus.WB_EN_in         = 1'($urandom);
    bus.Mem_R_EN_in      = ($urandom_range(0, 3) == 0);
    bus.Mem_W_EN_in      = ($urandom_range(0, 3) == 0);
    bus.EXE_CMD_in       = 4'($urandom_range(0, 15));
    bus.B_in             = ($urandom_range(0, 7) == 0);
    bus.S_in             = 1'($urandom);
    bus.imm_in           = 1'($urandom);
    bus.pc_in            = $urandom;
    bus.Val_Rn_in        = ($urandom_range(0, 7) == 0) ? 32'h7FFF_FFFF : $urandom;
    bus.Val_Rm_in        = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
    bus.shift_operand_in = 12'($urandom);
    bus.signed_imm_24_in = 24'($urandom);
    bus.dest_in          = 4'($urandom);
  endtask

  task automatic drive_vec(input vec_t v, input int idx);
    bus.EXE_CMD_in       = v.cmd;
    bus.S_in             = v.s;
    bus.imm_in           = v.imm;
    bus.Mem_R_EN_in      = v.mr;
    bus.Mem_W_EN_in      = v.mw;
    bus.Val_Rn_in        = v.rn;
    bus.Val_Rm_in        = v.rm;
    bus.shift_operand_in = v.so;
    bus.WB_EN_in         = 1'b1;
    bus.B_in             = 1'b0;
    bus.dest_in          = 4'(idx);
    bus.pc_in            = $urandom;
    bus.signed_imm_24_in = 24'($urandom);
  endtask

  initial begin
    //          cmd   s     imm   mr    mw    rn             rm             so       res            st
    vecs[0]  = '{4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'h0,        12'h001, 32'h8000_0000, 4'b1001};
    vecs[1]  = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5,         32'h0,        12'h005, 32'h0,         4'b0110};
    vecs[2]  = '{4'h5, 1'b1, 1'b1, 1'b0, 1'b0, 32'h5,         32'h0,        12'h002, 32'h3,         4'b0010};
    vecs[3]  = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'hF,        12'h260, 32'hF000_0000, 4'b0010};
    vecs[4]  = '{4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0,        12'h4FF, 32'hFF00_0000, 4'b0010};
    vecs[5]  = '{4'h2, 1'b0, 1'b0, 1'b1, 1'b0, 32'h100,       32'h0,        12'h123, 32'h223,       4'b0010};
    vecs[6]  = '{4'h3, 1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,        12'h001, 32'h1,         4'b0010};
    vecs[7]  = '{4'h6, 1'b1, 1'b0, 1'b0, 1'b0, 32'hF0F0,      32'hFF00,     12'h000, 32'hF000,      4'b0010};
    vecs[8]  = '{4'h8, 1'b1, 1'b0, 1'b0, 1'b0, 32'h5,         32'h5,        12'h000, 32'h0,         4'b0110};
    vecs[9]  = '{4'h9, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        12'h000, 32'hFFFF_FFFF, 4'b1010};
    vecs[10] = '{4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1234,      32'h5678,     12'h000, 32'h0,         4'b1010};
    vecs[11] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_0000, 12'h240, 32'hF800_0000, 4'b1010};
    vecs[12] = '{4'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_0000, 12'h220, 32'h0800_0000, 4'b1010};
    vecs[13] = '{4'h4, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000, 32'h0,        12'h001, 32'h7FFF_FFFF, 4'b0011};
    vecs[14] = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1000,      32'hABCD,     12'hFFF, 32'h1FFF,      4'b0011};
    vecs[15] = '{4'h7, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0,        12'h000, 32'h0,         4'b0111};
    vecs[16] = '{4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 32'h1,         32'h3,        12'h400, 32'h301,       4'b0111};
    vecs[17] = '{4'h7, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h8000_0001, 12'h0E0, 32'hC000_0000, 4'b0111};

    {e_wb, e_mr, e_mw} = 3'b0;
    e_res = 0; e_st = 0; e_dest = 0; m_status = 0;

    // Reset with random inputs, second cycle also with freeze asserted.
    rst = 1'b1; freeze = 1'b0;
    rand_inputs();
    step("reset0");
    freeze = 1'b1;
    rand_inputs();
    step("reset1");
    rst = 1'b0; freeze = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive_vec(vecs[i], i);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d/tbl_result", i), alu_result, vecs[i].exp_res);
      chk($sformatf("vec%0d/tbl_status", i), {28'b0, status}, {28'b0, vecs[i].exp_st});
    end

    // Branch with S set: target same cycle, enables cleared, status untouched.
    drive_vec(vecs[0], 5);
    bus.B_in = 1'b1; bus.Mem_R_EN_in = 1'b1;
    bus.pc_in = 32'h100; bus.signed_imm_24_in = 24'hFFFFFE;
    #1;
    chk("branch/br_taken_now", {31'b0, br_taken}, 32'd1);
    chk("branch/br_addr_now", br_addr, 32'hF8);
    step("branch");
    chk("branch/status_kept", {28'b0, status}, 32'b0111);
    chk("branch/wb_cleared", {29'b0, WB_EN, Mem_R_EN, Mem_W_EN}, 32'b0);
    bus.B_in = 1'b0;

    // Freeze for three cycles with a status-updating ADD presented, then release it.
    drive_vec(vecs[0], 9);
    bus.Val_Rn_in = 32'h1; bus.shift_operand_in = 12'h001;
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step($sformatf("freeze%0d", i));
      chk($sformatf("freeze%0d/status_held", i), {28'b0, status}, 32'b0111);
      chk($sformatf("freeze%0d/result_held", i), alu_result, 32'h8000_0000);
    end
    freeze = 1'b0;
    step("unfreeze");
    chk("unfreeze/status", {28'b0, status}, 32'b0000);
    chk("unfreeze/result", alu_result, 32'h2);

    // Random stimulus against the reference model.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      rst    = ($urandom_range(0, 31) == 0);
      freeze = ($urandom_range(0, 3) == 0);
      step($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
